// File: rtl/me_pkg.sv
// ----------------------------------------------------------------------------
// me_pkg
// Constants and FSM encoding shared by the motion-estimation argmin stage,
// the candidate-distance helper and the downstream serial result formatter.
// ----------------------------------------------------------------------------
package me_pkg;

    localparam int SAD_W  = 14;              // SAD width
    localparam int POS_W  = 4;               // candidate index width per axis
    localparam int RANGE  = 15;              // candidates per axis
    localparam int CENTRE = (RANGE - 1) / 2; // zero-motion index
    localparam int DIST_W = 5;               // |dx|+|dy| fits in 0..14

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } me_state_t;

endpackage

// File: rtl/me_cand_dist.sv
// ----------------------------------------------------------------------------
// me_cand_dist
// Combinational Manhattan distance of a candidate index from the zero-motion
// centre: |cx-CENTRE| + |cy-CENTRE|.
//   i_cx   : candidate x index, 0..RANGE-1
//   i_cy   : candidate y index, 0..RANGE-1
//   o_dist : distance, 0..2*CENTRE
// ----------------------------------------------------------------------------
module me_cand_dist
    import me_pkg::*;
(
    input  logic [POS_W-1:0]  i_cx,
    input  logic [POS_W-1:0]  i_cy,
    output logic [DIST_W-1:0] o_dist
);

    localparam logic [POS_W-1:0] C_CENTRE = POS_W'(CENTRE);

    logic [POS_W-1:0] w_dx;
    logic [POS_W-1:0] w_dy;

    assign w_dx   = (i_cx >= C_CENTRE) ? (i_cx - C_CENTRE) : (C_CENTRE - i_cx);
    assign w_dy   = (i_cy >= C_CENTRE) ? (i_cy - C_CENTRE) : (C_CENTRE - i_cy);
    assign o_dist = DIST_W'(w_dx) + DIST_W'(w_dy);

endmodule

// File: rtl/sad_min_select.sv
// ----------------------------------------------------------------------------
// sad_min_select
// Argmin stage of the full-search motion estimator. Accepts one SAD per
// qualified cycle for every candidate of a RANGE x RANGE window in raster
// order, tracks the minimum (ties broken towards the centre, then towards the
// earlier candidate) and publishes it with a one-cycle done pulse.
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : begin (or restart) a window scan
//   sad_in     : candidate SAD, qualified by sad_valid
//   busy       : scan in progress
//   done       : one-cycle pulse, out_* hold a new result
//   out_sad    : minimum SAD of the last completed window
//   out_x/y    : unsigned index 0..RANGE-1 of that minimum
//
// state | meaning
// IDLE  | waiting for start, sad_valid ignored
// SCAN  | accepting candidates at (cx, cy)
// ----------------------------------------------------------------------------
module sad_min_select
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SAD_W-1:0] sad_in,
    input  logic             sad_valid,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] out_sad,
    output logic [POS_W-1:0] out_x,
    output logic [POS_W-1:0] out_y
);

    localparam logic [POS_W-1:0] C_LAST = POS_W'(RANGE - 1);

    me_state_t r_state;
    me_state_t w_state_nxt;

    logic [POS_W-1:0]  r_cx;
    logic [POS_W-1:0]  r_cy;
    logic [SAD_W-1:0]  r_best_sad;
    logic [POS_W-1:0]  r_best_x;
    logic [POS_W-1:0]  r_best_y;
    logic [DIST_W-1:0] r_best_dist;
    logic              r_done;
    logic [SAD_W-1:0]  r_out_sad;
    logic [POS_W-1:0]  r_out_x;
    logic [POS_W-1:0]  r_out_y;

    logic [DIST_W-1:0] w_dist;
    logic              w_first;
    logic              w_last;
    logic              w_better;
    logic              w_accept;
    logic              w_complete;
    logic              w_clear;
    logic [SAD_W-1:0]  w_nbest_sad;
    logic [POS_W-1:0]  w_nbest_x;
    logic [POS_W-1:0]  w_nbest_y;
    logic [DIST_W-1:0] w_nbest_dist;

    me_cand_dist u_dist (
        .i_cx   (r_cx),
        .i_cy   (r_cy),
        .o_dist (w_dist)
    );

    assign w_first = (r_cx == '0) && (r_cy == '0);
    assign w_last  = (r_cx == C_LAST) && (r_cy == C_LAST);

    // (0,0) seeds the running best, so no explicit clear of best_* is needed.
    assign w_better = w_first
                   || (sad_in < r_best_sad)
                   || ((sad_in == r_best_sad) && (w_dist < r_best_dist));

    assign w_nbest_sad  = w_better ? sad_in : r_best_sad;
    assign w_nbest_x    = w_better ? r_cx   : r_best_x;
    assign w_nbest_y    = w_better ? r_cy   : r_best_y;
    assign w_nbest_dist = w_better ? w_dist : r_best_dist;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state and control strobes ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_clear     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (sad_valid && w_last) begin
                    // Completion wins over a coincident start; the start then
                    // opens the next window straight away.
                    w_complete  = 1'b1;
                    w_clear     = start;
                    w_state_nxt = start ? ST_SCAN : ST_IDLE;
                end else if (start) begin
                    w_clear = 1'b1;
                end else if (sad_valid) begin
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- Counters, running best, result ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx        <= '0;
            r_cy        <= '0;
            r_best_sad  <= '0;
            r_best_x    <= '0;
            r_best_y    <= '0;
            r_best_dist <= '0;
            r_done      <= 1'b0;
            r_out_sad   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            r_done <= w_complete;

            if (w_clear) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (w_accept) begin
                if (r_cx == C_LAST) begin
                    r_cx <= '0;
                    r_cy <= r_cy + POS_W'(1);
                end else begin
                    r_cx <= r_cx + POS_W'(1);
                end
            end

            if (w_accept) begin
                r_best_sad  <= w_nbest_sad;
                r_best_x    <= w_nbest_x;
                r_best_y    <= w_nbest_y;
                r_best_dist <= w_nbest_dist;
            end

            if (w_complete) begin
                r_out_sad <= w_nbest_sad;
                r_out_x   <= w_nbest_x;
                r_out_y   <= w_nbest_y;
            end
        end
    end

    assign busy    = (r_state == ST_SCAN);
    assign done    = r_done;
    assign out_sad = r_out_sad;
    assign out_x   = r_out_x;
    assign out_y   = r_out_y;

endmodule

// File: tb/tb_sad_min_select.sv
module tb_sad_min_select;
    import me_pkg::*;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } res_t;

    localparam int NCAND = RANGE * RANGE;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [SAD_W-1:0] sad_in;
    logic             sad_valid;
    logic             busy;
    logic             done;
    logic [SAD_W-1:0] out_sad;
    logic [POS_W-1:0] out_x;
    logic [POS_W-1:0] out_y;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_acc_cyc = -1;
    int   done_count = 0;
    int   busy_cycles = 0;
    int   sads [NCAND];
    res_t sbq [$];

    sad_min_select dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sad_in    (sad_in),
        .sad_valid (sad_valid),
        .busy      (busy),
        .done      (done),
        .out_sad   (out_sad),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int cdist(input int i);
        int x, y, dx, dy;
        x  = i % RANGE;
        y  = i / RANGE;
        dx = (x >= CENTRE) ? x - CENTRE : CENTRE - x;
        dy = (y >= CENTRE) ? y - CENTRE : CENTRE - y;
        return dx + dy;
    endfunction

    function automatic res_t model();
        int   b;
        res_t r;
        b = 0;
        for (int i = 1; i < NCAND; i++) begin
            if (sads[i] < sads[b] || (sads[i] == sads[b] && cdist(i) < cdist(b)))
                b = i;
        end
        r.sad = SAD_W'(sads[b]);
        r.x   = POS_W'(b % RANGE);
        r.y   = POS_W'(b / RANGE);
        return r;
    endfunction

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (done) begin
                res_t exp_r;
                done_count++;
                tests++;
                assert (sbq.size() > 0)
                else begin
                    fails++;
                    $error("FAIL unexpected_done: observed done with empty scoreboard, expected no done");
                end
                if (sbq.size() > 0) begin
                    exp_r = sbq.pop_front();
                    tests++;
                    assert ({out_sad, out_x, out_y} === exp_r)
                    else begin
                        fails++;
                        $error("FAIL result: observed sad=%0d x=%0d y=%0d, expected sad=%0d x=%0d y=%0d",
                               out_sad, out_x, out_y, exp_r.sad, exp_r.x, exp_r.y);
                    end
                    tests++;
                    assert (cyc === last_acc_cyc)
                    else begin
                        fails++;
                        $error("FAIL done_latency: observed done at cycle %0d, expected cycle %0d",
                               cyc, last_acc_cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_window(input bit gaps, input bit sv_with_start,
                                input bit no_start, input bit start_at_end);
        sbq.push_back(model());
        if (!no_start) begin
            start     = 1'b1;
            sad_valid = sv_with_start;
            sad_in    = '0;
            tick();
            start     = 1'b0;
            sad_valid = 1'b0;
        end
        for (int i = 0; i < NCAND; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 3));
                for (int k = 0; k < g; k++) tick();
            end
            sad_valid = 1'b1;
            sad_in    = SAD_W'(sads[i]);
            if (i == NCAND - 1) begin
                last_acc_cyc = cyc + 1;
                start        = start_at_end;
            end
            tick();
            sad_valid = 1'b0;
            start     = 1'b0;
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NCAND; i++) sads[i] = v;
    endtask

    initial begin
        int dc;
        rst_n     = 1'b0;
        start     = 1'b0;
        sad_valid = 1'b0;
        sad_in    = '0;
        repeat (3) tick();

        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_out", int'({out_sad, out_x, out_y}), 0);
        rst_n = 1'b1;
        tick();

        // 1: flat SAD, centre wins on distance
        dc = done_count;
        fill(100);
        drive_window(0, 0, 0, 0);
        repeat (3) tick();
        check_int("flat_done_count", done_count - dc, 1);
        check_int("flat_busy_after", int'(busy), 0);

        // 2: single minimum, valid every cycle, busy duration
        dc = done_count;
        fill(500);
        sads[11 * RANGE + 3] = 5;
        busy_cycles = 0;
        drive_window(0, 0, 0, 0);
        repeat (3) tick();
        check_int("single_done_count", done_count - dc, 1);
        check_int("busy_cycles", busy_cycles, NCAND);

        // 3: equal SAD and distance at corners, earlier wins
        dc = done_count;
        fill(900);
        sads[0] = 20;
        sads[NCAND - 1] = 20;
        drive_window(0, 0, 0, 0);
        repeat (3) tick();
        check_int("corner_done_count", done_count - dc, 1);

        // 4: distance tie-break with gaps; SAD 0 alongside start is ignored
        dc = done_count;
        fill(1000);
        sads[6 * RANGE + 7] = 8;
        sads[8 * RANGE + 7] = 8;
        sads[7 * RANGE + 9] = 8;
        drive_window(1, 1, 0, 0);
        repeat (3) tick();
        check_int("gaps_done_count", done_count - dc, 1);

        // 5: abort after 100 candidates with a planted 1, then full window
        dc = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sad_valid = 1'b1;
            sad_in    = (i == 50) ? SAD_W'(1) : SAD_W'(200);
            tick();
        end
        sad_valid = 1'b0;
        fill(200);
        sads[1 * RANGE + 12] = 3;
        drive_window(0, 0, 0, 0);
        repeat (3) tick();
        check_int("abort_done_count", done_count - dc, 1);

        // 6: reset mid-scan, then a full random window
        dc = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sad_valid = 1'b1;
            sad_in    = SAD_W'(1);
            tick();
        end
        sad_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_out", int'({out_sad, out_x, out_y}), 0);
        check_int("rst_no_done", done_count - dc, 0);
        for (int i = 0; i < NCAND; i++) sads[i] = int'($urandom_range(10, 16000));
        drive_window(1, 0, 0, 0);
        repeat (3) tick();
        check_int("rst_done_count", done_count - dc, 1);

        // 7: start coincident with the last candidate opens the next window
        dc = done_count;
        for (int i = 0; i < NCAND; i++) sads[i] = int'($urandom_range(50, 9000));
        drive_window(0, 0, 0, 1);
        check_int("b2b_busy", int'(busy), 1);
        for (int i = 0; i < NCAND; i++) sads[i] = int'($urandom_range(50, 9000));
        sads[4 * RANGE + 2] = 7;
        drive_window(0, 0, 1, 0);
        repeat (3) tick();
        check_int("b2b_done_count", done_count - dc, 2);
        check_int("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
